clock_set_controller: RTL and testbench
=======================================

// Module: clock_set_controller
//
// PURPOSE
// - Time-setting sequencer for the 24 h clock counter (sec/min/hour).
// - Takes single-cycle button pulses (already debounced upstream) and walks the user through editing hours, then minutes.
// - While editing, it freezes the counter. It then writes the edited time back with a one-cycle load strobe.
// - Sits between the button conditioning logic and the clock counter. Drives the counter's hold/load inputs and the display blink.
//
// PARAMETERS
// HOUR_MAX   23  largest hour value; edit wraps HOUR_MAX<->0
// MIN_MAX    59  largest minute value; edit wraps MIN_MAX<->0
// TIMEOUT_S  10  tick pulses with no button activity before an edit is abandoned (>=1)
//
// PORTS
// clk        in   1  system clock
// reset      in   1  reset, asynchronous, active-high
// tick       in   1  one-cycle pulse per second from the clock timebase
// btn_mode   in   1  one-cycle pulse: enter edit / advance field / commit
// btn_inc    in   1  one-cycle pulse: increment field being edited
// btn_dec    in   1  one-cycle pulse: decrement field being edited
// btn_cancel in   1  one-cycle pulse: abandon edit, no load
// cur_hour   in   5  live hour from clock counter
// cur_min    in   6  live minute from clock counter
// hold       out  1  1 = clock counter must not advance
// load       out  1  one-cycle strobe: counter takes load_hour/load_min/load_sec
// load_hour  out  5  hour value to load (valid while edit_hour|edit_min|load)
// load_min   out  6  minute value to load (same validity)
// load_sec   out  6  constant 0: seconds restart at commit
// edit_hour  out  1  1 while hour field is being edited
// edit_min   out  1  1 while minute field is being edited
// blink      out  1  display blank phase for the edited field; 0 outside edit
//
// BEHAVIOUR
// - All outputs registered. Reset values:
//   - state=RUN; hold=0, load=0.
//   - load_hour=0, load_min=0, load_sec=0.
//   - edit_hour=0, edit_min=0, blink=0.
//   - Timeout counter=0.
// - FSM states: RUN, EDIT_HOUR, EDIT_MIN, COMMIT. Button pulse sampled at edge N; effect visible after edge N.
// - Button priority per cycle: btn_cancel > btn_mode > (btn_inc/btn_dec). btn_inc&btn_dec together = no change.
// - RUN:
//   - btn_mode -> EDIT_HOUR; shadow load_hour<=cur_hour, load_min<=cur_min; hold<=1.
//   - All other buttons are ignored.
// - EDIT_HOUR:
//   - inc: load_hour+1, HOUR_MAX wraps to 0.
//   - dec: load_hour-1, 0 wraps to HOUR_MAX.
//   - btn_mode -> EDIT_MIN.
// - EDIT_MIN:
//   - inc: load_min+1, MIN_MAX wraps to 0.
//   - dec: load_min-1, 0 wraps to MIN_MAX.
//   - btn_mode -> COMMIT.
// - COMMIT:
//   - Single cycle: load=1, hold=1; then RUN unconditionally, with load=0, hold=0.
//   - Buttons arriving during COMMIT are ignored.
// - btn_cancel in EDIT_* -> RUN; hold<=0; no load pulse; shadow regs keep values (don't-care).
// - Timeout:
//   - Counter is cleared on entry to EDIT_HOUR and on any accepted button pulse in EDIT_*.
//   - It increments on tick while in EDIT_*.
//   - On the tick that makes it reach TIMEOUT_S, go to RUN as for cancel.
//   - A button pulse in the same cycle as that tick wins; the counter is cleared and no timeout occurs.
// - blink:
//   - Cleared to 0 on entry to EDIT_HOUR and on every field change (mode advance).
//   - Toggles on each tick while in EDIT_*; 0 in RUN and COMMIT.
// - edit_hour=1 only in EDIT_HOUR; edit_min=1 only in EDIT_MIN.
// - hold=1 in EDIT_HOUR, EDIT_MIN, COMMIT.
// - The counter ignores tick while hold=1, so the shadow time cannot race the counter.
// - Arithmetic:
//   - Wrap comparisons are done on full field width.
//   - Out-of-range cur_* captured as-is; inc from >HOUR_MAX/MIN_MAX wraps to 0.
// - Reset asserted mid-edit: immediate return to RUN, hold=0, no load.
//
// TESTING
// - Reset, then cur=13:45, mode -> edit_hour=1, hold=1, load_hour=13, load_min=45 next cycle; no load.
// - From hour=23, inc -> 0; dec from 0 -> 23; min 59 inc -> 0; inc+dec same cycle -> unchanged.
// - Edit to 07:30, mode, mode -> exactly one cycle load=1 with 7/30/0, then hold=0, state RUN.
// - Enter edit, cancel in EDIT_MIN -> RUN, hold=0, load never asserted.
// - Enter edit, 10 ticks no buttons -> RUN after 10th tick, no load; inc on 10th-tick cycle -> stays in edit.
// - Assert reset during EDIT_HOUR -> all outputs 0 asynchronously; blink toggles per tick only while editing.

Source files
------------

// File: rtl/clock_set_controller.sv
// Time-setting sequencer for the 24 h clock counter: freezes the counter, lets the
// user edit hours then minutes with single-cycle buttons, and writes back with a load strobe.
module clock_set_controller #(
   parameter int unsigned HOUR_MAX  = 23,
   parameter int unsigned MIN_MAX   = 59,
   parameter int unsigned TIMEOUT_S = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic       btn_cancel,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   output logic       hold,
   output logic       load,
   output logic [4:0] load_hour,
   output logic [5:0] load_min,
   output logic [5:0] load_sec,
   output logic       edit_hour,
   output logic       edit_min,
   output logic       blink
);

   localparam int unsigned HW = 5;
   localparam int unsigned MW = 6;
   localparam int unsigned SW = 6;
   localparam int unsigned CW = $clog2(TIMEOUT_S + 1);

   typedef enum logic [1:0] {RUN, EDIT_HOUR, EDIT_MIN, COMMIT} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
   logic [HW-1:0] hour_nxt;
   logic [MW-1:0] min_nxt;
   logic          blink_nxt;
   logic          adj_c, editing_c, timeout_c;

   // inc and dec together cancel out and do not count as activity
   assign adj_c     = btn_inc ^ btn_dec;
   assign editing_c = (state == EDIT_HOUR) || (state == EDIT_MIN);
   assign timeout_c = editing_c && tick && !btn_cancel && !btn_mode && !adj_c &&
                      ((tmo_cnt + CW'(1)) == CW'(TIMEOUT_S));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (!btn_cancel && btn_mode) state_nxt = EDIT_HOUR;
         end
         EDIT_HOUR: begin
            if (btn_cancel)     state_nxt = RUN;
            else if (btn_mode)  state_nxt = EDIT_MIN;
            else if (timeout_c) state_nxt = RUN;
         end
         EDIT_MIN: begin
            if (btn_cancel)     state_nxt = RUN;
            else if (btn_mode)  state_nxt = COMMIT;
            else if (timeout_c) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   // shadow time, blink phase and inactivity counter for the next cycle
   always_comb begin
      hour_nxt    = load_hour;
      min_nxt     = load_min;
      blink_nxt   = 1'b0;
      tmo_cnt_nxt = '0;
      case (state)
         RUN: begin
            if (state_nxt == EDIT_HOUR) begin
               hour_nxt = cur_hour;
               min_nxt  = cur_min;
            end
         end
         EDIT_HOUR, EDIT_MIN: begin
            if (!btn_cancel && !btn_mode) begin
               if (adj_c && state == EDIT_HOUR) begin
                  if (btn_inc) hour_nxt = (load_hour >= HW'(HOUR_MAX)) ? '0 : load_hour + HW'(1);
                  else         hour_nxt = (load_hour == '0) ? HW'(HOUR_MAX) : load_hour - HW'(1);
               end
               if (adj_c && state == EDIT_MIN) begin
                  if (btn_inc) min_nxt = (load_min >= MW'(MIN_MAX)) ? '0 : load_min + MW'(1);
                  else         min_nxt = (load_min == '0) ? MW'(MIN_MAX) : load_min - MW'(1);
               end
               blink_nxt   = tick ? ~blink : blink;
               tmo_cnt_nxt = adj_c ? '0 : (tick ? tmo_cnt + CW'(1) : tmo_cnt);
               if (timeout_c) begin
                  blink_nxt   = 1'b0;
                  tmo_cnt_nxt = '0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold      <= 1'b0;
         load      <= 1'b0;
         load_hour <= '0;
         load_min  <= '0;
         edit_hour <= 1'b0;
         edit_min  <= 1'b0;
         blink     <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         hold      <= (state_nxt != RUN);
         load      <= (state_nxt == COMMIT);
         load_hour <= hour_nxt;
         load_min  <= min_nxt;
         edit_hour <= (state_nxt == EDIT_HOUR);
         edit_min  <= (state_nxt == EDIT_MIN);
         blink     <= blink_nxt;
         tmo_cnt   <= tmo_cnt_nxt;
      end
   end

   // seconds always restart from zero at commit
   assign load_sec = SW'(0);

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed scenarios plus random button traffic,
// every cycle compared against a behavioural model of the time-setting sequence.
module tb_clock_set_controller;

   localparam int HOUR_MAX  = 23;
   localparam int MIN_MAX   = 59;
   localparam int TIMEOUT_S = 10;
   localparam int M_RUN = 0, M_HOUR = 1, M_MIN = 2, M_COMMIT = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_cancel = 1'b0;
   logic [4:0] cur_hour = '0;
   logic [5:0] cur_min = '0;
   logic       hold, load, edit_hour, edit_min, blink;
   logic [4:0] load_hour;
   logic [5:0] load_min, load_sec;

   int n_checks = 0;
   int n_errors = 0;

   int         m_phase;
   int         m_h, m_m, m_idle;
   bit         m_blink;

   clock_set_controller #(.HOUR_MAX(HOUR_MAX), .MIN_MAX(MIN_MAX), .TIMEOUT_S(TIMEOUT_S)) dut (
      .clk(clk), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .btn_dec(btn_dec), .btn_cancel(btn_cancel), .cur_hour(cur_hour), .cur_min(cur_min),
      .hold(hold), .load(load), .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
      .edit_hour(edit_hour), .edit_min(edit_min), .blink(blink)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int wrap_up(input int v, input int vmax);
      return (v > vmax) ? 0 : (v + 1) % (vmax + 1);
   endfunction

   function automatic int wrap_down(input int v, input int vmax);
      return (v == 0) ? vmax : v - 1;
   endfunction

   task automatic model_reset();
      m_phase = M_RUN; m_h = 0; m_m = 0; m_idle = 0; m_blink = 0;
   endtask

   task automatic model_update(input bit t, input bit md, input bit i, input bit d, input bit c,
                               input int ch, input int cm);
      bit adj;
      adj = i ^ d;
      if (m_phase == M_RUN) begin
         if (!c && md) begin
            m_phase = M_HOUR; m_h = ch; m_m = cm; m_idle = 0; m_blink = 0;
         end
      end else if (m_phase == M_COMMIT) begin
         m_phase = M_RUN; m_blink = 0;
      end else if (c) begin
         m_phase = M_RUN; m_blink = 0;
      end else if (md) begin
         m_phase = (m_phase == M_HOUR) ? M_MIN : M_COMMIT;
         m_blink = 0; m_idle = 0;
      end else begin
         if (adj) begin
            if (m_phase == M_HOUR) m_h = i ? wrap_up(m_h, HOUR_MAX) : wrap_down(m_h, HOUR_MAX);
            else                   m_m = i ? wrap_up(m_m, MIN_MAX) : wrap_down(m_m, MIN_MAX);
            m_idle = 0;
         end
         if (t) begin
            m_blink = !m_blink;
            if (!adj) begin
               m_idle++;
               if (m_idle >= TIMEOUT_S) begin
                  m_phase = M_RUN; m_blink = 0; m_idle = 0;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [4:0] exp_flags;
      exp_flags = {m_phase != M_RUN, m_phase == M_COMMIT, m_phase == M_HOUR,
                   m_phase == M_MIN, m_blink};
      check("flags", 32'({hold, load, edit_hour, edit_min, blink}), 32'(exp_flags));
      check("load_sec", 32'(load_sec), 32'd0);
      if (m_phase != M_RUN)
         check("shadow", 32'({load_hour, load_min}), 32'({5'(m_h), 6'(m_m)}));
   endtask

   // one clock with the given button pulses; outputs checked 1 time unit after the edge
   task automatic step(input bit t, input bit md, input bit i, input bit d, input bit c);
      tick = t; btn_mode = md; btn_inc = i; btn_dec = d; btn_cancel = c;
      @(posedge clk);
      model_update(t, md, i, d, c, int'(cur_hour), int'(cur_min));
      #1;
      tick = 0; btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_cancel = 0;
      compare_all();
   endtask

   task automatic async_reset();
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("async_rst", 32'({hold, load, edit_hour, edit_min, blink, load_hour, load_min}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      model_reset();
      #12;
      check("reset_out", 32'({hold, load, edit_hour, edit_min, blink, load_hour, load_min, load_sec}), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // entry captures live time
      cur_hour = 13; cur_min = 45;
      step(0, 1, 0, 0, 0);
      check("enter_13", 32'({edit_hour, hold, load}), 32'b110);
      check("enter_hm", 32'({load_hour, load_min}), 32'({5'd13, 6'd45}));

      // hour/minute wrap and inc+dec neutrality
      async_reset();
      cur_hour = 23; cur_min = 59;
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      check("hour_23_inc", 32'(load_hour), 32'd0);
      step(0, 0, 0, 1, 0);
      check("hour_0_dec", 32'(load_hour), 32'd23);
      step(0, 0, 1, 1, 0);
      check("hour_incdec", 32'(load_hour), 32'd23);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      check("min_59_inc", 32'(load_min), 32'd0);
      step(0, 0, 0, 1, 0);
      check("min_0_dec", 32'(load_min), 32'd59);

      // full edit to 07:30 and commit
      async_reset();
      cur_hour = 5; cur_min = 28;
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      check("commit", 32'({load, hold, load_hour, load_min, load_sec}), 32'({2'b11, 5'd7, 6'd30, 6'd0}));
      step(1, 1, 0, 0, 0);
      check("after_commit", 32'({load, hold, edit_hour}), 32'b000);

      // cancel in minute field
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      check("cancel", 32'({load, hold, edit_min}), 32'b000);

      // blink toggles per tick only while editing
      step(1, 0, 0, 0, 0);
      check("blink_run", 32'(blink), 32'd0);
      step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("blink_1", 32'(blink), 32'd1);
      step(1, 0, 0, 0, 0);
      check("blink_0", 32'(blink), 32'd0);
      step(0, 0, 0, 0, 1);

      // inactivity timeout, and a button on the 10th tick rescues the edit
      step(0, 1, 0, 0, 0);
      for (int k = 0; k < TIMEOUT_S - 1; k++) step(1, 0, 0, 0, 0);
      check("tmo_9", 32'(edit_hour), 32'd1);
      step(1, 0, 0, 0, 0);
      check("tmo_10", 32'({hold, load, edit_hour}), 32'b000);
      step(0, 1, 0, 0, 0);
      for (int k = 0; k < TIMEOUT_S - 1; k++) step(1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0);
      check("tmo_saved", 32'({hold, edit_hour}), 32'b11);
      for (int k = 0; k < TIMEOUT_S - 1; k++) step(1, 0, 0, 0, 0);
      check("tmo_restart", 32'(edit_hour), 32'd1);
      step(1, 0, 0, 0, 0);
      check("tmo_again", 32'(hold), 32'd0);

      // random traffic: alternating busy and quiet profiles
      for (int blk = 0; blk < 20; blk++) begin
         int p_btn;
         p_btn = (blk % 2 == 0) ? 3 : 30;
         for (int k = 0; k < 200; k++) begin
            bit t, md, i, d, c;
            if ($urandom_range(0, 7) == 0) begin
               cur_hour = 5'($urandom_range(0, 31));
               cur_min  = 6'($urandom_range(0, 63));
            end
            t  = ($urandom_range(0, 1) == 1);
            md = ($urandom_range(0, 4 * p_btn) == 0);
            i  = ($urandom_range(0, p_btn) == 0);
            d  = ($urandom_range(0, p_btn) == 0);
            c  = ($urandom_range(0, 12 * p_btn) == 0);
            step(t, md, i, d, c);
            if ($urandom_range(0, 499) == 0) async_reset();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
